// File: rtl/lot_occupancy_counter_if.sv
// Bus between the parking-lot sensor FSM / display logic and the occupancy counter.
// The counter sits on the slave side; the producer of inc/dec and consumer of the displays is the master.
interface lot_occupancy_counter_if #(
  parameter int CW = 7
);
  logic          inc;
  logic          dec;
  logic          clear;
  logic          err_clr;
  logic [CW-1:0] count;
  logic [3:0]    bcd_tens;
  logic [3:0]    bcd_ones;
  logic [CW-1:0] free_spaces;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;

  modport slave (
    input  inc, dec, clear, err_clr,
    output count, bcd_tens, bcd_ones, free_spaces, full, empty, overflow, underflow
  );

  modport master (
    output inc, dec, clear, err_clr,
    input  count, bcd_tens, bcd_ones, free_spaces, full, empty, overflow, underflow
  );
endinterface

// File: rtl/lot_occupancy_counter.sv
// Saturating parking-lot occupancy counter: edge-detects inc/dec levels, keeps a binary and a
// parallel BCD count in 0..CAPACITY, and flags sticky overflow/underflow for the gate/display logic.
module lot_occupancy_counter #(
  parameter int CAPACITY = 20,
  parameter int CW       = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  lot_occupancy_counter_if.slave bus
);

  localparam logic [CW-1:0] CAP = CW'(CAPACITY);

  logic          inc_q, dec_q;
  logic          inc_ev, dec_ev;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          up, dn, ovf_set, unf_set;

  assign inc_ev = bus.inc & ~inc_q;
  assign dec_ev = bus.dec & ~dec_q;

  // Clear discards this cycle's events, so it also suppresses any error they would raise.
  always_comb begin
    up      = 1'b0;
    dn      = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (!bus.clear) begin
      if (inc_ev && !dec_ev) begin
        if (count_q != CAP) up      = 1'b1;
        else                ovf_set = 1'b1;
      end else if (dec_ev && !inc_ev) begin
        if (count_q != '0)  dn      = 1'b1;
        else                unf_set = 1'b1;
      end
    end
  end

  // BCD digits run as their own counter alongside the binary one rather than being converted.
  always_comb begin
    count_d = count_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    if (bus.clear) begin
      count_d = '0;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
    end else if (up) begin
      count_d = count_q + CW'(1);
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (dn) begin
      count_d = count_q - CW'(1);
      if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  // A fresh error beats err_clr in the same cycle.
  always_comb begin
    ovf_d = (ovf_q & ~bus.err_clr) | ovf_set;
    unf_d = (unf_q & ~bus.err_clr) | unf_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      count_q <= '0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      inc_q   <= bus.inc;
      dec_q   <= bus.dec;
      count_q <= count_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.count       = count_q;
  assign bus.bcd_tens    = tens_q;
  assign bus.bcd_ones    = ones_q;
  assign bus.free_spaces = CAP - count_q;
  assign bus.full        = (count_q == CAP);
  assign bus.empty       = (count_q == '0);
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;

endmodule

// File: tb/tb_lot_occupancy_counter.sv
// Scoreboard bench for lot_occupancy_counter: a driver steps an arithmetic occupancy model and
// queues the expected outputs; a monitor pops and compares one entry after each clock edge.
module tb_lot_occupancy_counter;
  localparam int CAPACITY = 20;
  localparam int CW       = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lot_occupancy_counter_if #(.CW(CW)) bus ();

  lot_occupancy_counter #(.CAPACITY(CAPACITY), .CW(CW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int count;
    int tens;
    int ones;
    int free;
    int full;
    int empty;
    int ovf;
    int unf;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: occupancy as a plain integer plus last-seen input levels.
  int m_occ, m_ovf, m_unf, m_pi, m_pd;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_occ = 0; m_ovf = 0; m_unf = 0; m_pi = 0; m_pd = 0;
  endfunction

  function automatic void model_step(input int i, input int d, input int c, input int e);
    int ie, de, no, nu;
    ie = (i != 0) && (m_pi == 0);
    de = (d != 0) && (m_pd == 0);
    m_pi = i; m_pd = d;
    no = 0; nu = 0;
    if (c != 0)        m_occ = 0;
    else if (ie && de) m_occ = m_occ;
    else if (ie) begin
      if (m_occ < CAPACITY) m_occ++;
      else                  no = 1;
    end else if (de) begin
      if (m_occ > 0) m_occ--;
      else           nu = 1;
    end
    m_ovf = ((m_ovf != 0) && (e == 0)) || (no != 0);
    m_unf = ((m_unf != 0) && (e == 0)) || (nu != 0);
  endfunction

  function automatic exp_t model_out();
    exp_t x;
    x.count = m_occ;
    x.tens  = m_occ / 10;
    x.ones  = m_occ % 10;
    x.free  = CAPACITY - m_occ;
    x.full  = (m_occ == CAPACITY);
    x.empty = (m_occ == 0);
    x.ovf   = m_ovf;
    x.unf   = m_unf;
    return x;
  endfunction

  task automatic step(input int i, input int d, input int c, input int e);
    @(negedge clk);
    bus.inc     = i[0];
    bus.dec     = d[0];
    bus.clear   = c[0];
    bus.err_clr = e[0];
    model_step(i, d, c, e);
    q.push_back(model_out());
  endtask

  task automatic pulse_inc(input int n);
    for (int k = 0; k < n; k++) begin step(1, 0, 0, 0); step(0, 0, 0, 0); end
  endtask

  task automatic pulse_dec(input int n);
    for (int k = 0; k < n; k++) begin step(0, 1, 0, 0); step(0, 0, 0, 0); end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_count"}, int'(bus.count), 0);
    chk({tag, "_tens"},  int'(bus.bcd_tens), 0);
    chk({tag, "_ones"},  int'(bus.bcd_ones), 0);
    chk({tag, "_free"},  int'(bus.free_spaces), CAPACITY);
    chk({tag, "_full"},  int'(bus.full), 0);
    chk({tag, "_empty"}, int'(bus.empty), 1);
    chk({tag, "_ovf"},   int'(bus.overflow), 0);
    chk({tag, "_unf"},   int'(bus.underflow), 0);
  endtask

  // Monitor: every edge the DUT presents a new state; compare it against the oldest queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("count", int'(bus.count), x.count);
        chk("bcd_tens", int'(bus.bcd_tens), x.tens);
        chk("bcd_ones", int'(bus.bcd_ones), x.ones);
        chk("free_spaces", int'(bus.free_spaces), x.free);
        chk("full", int'(bus.full), x.full);
        chk("empty", int'(bus.empty), x.empty);
        chk("overflow", int'(bus.overflow), x.ovf);
        chk("underflow", int'(bus.underflow), x.unf);
      end
    end
  end

  initial begin
    int pi, pd, drain;
    bus.inc = 1'b0; bus.dec = 1'b0; bus.clear = 1'b0; bus.err_clr = 1'b0;
    model_reset();
    #3;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Three separate two-cycle entry pulses.
    for (int k = 0; k < 3; k++) begin step(1, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0); end

    // A level held for 50 cycles is a single entry.
    step(0, 0, 1, 0);
    repeat (50) step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Fill, overflow, clear the error.
    step(0, 0, 1, 0);
    pulse_inc(CAPACITY);
    pulse_inc(1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Borrow across the tens digit, then underflow from empty.
    pulse_dec(10);
    pulse_dec(1);
    step(0, 0, 1, 0);
    pulse_dec(1);
    step(0, 0, 0, 1);

    // Simultaneous edges cancel; clear beats an inc edge.
    step(0, 0, 1, 0);
    pulse_inc(5);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    pulse_inc(2);
    step(1, 0, 1, 0);
    step(0, 0, 0, 0);

    // Underflow arriving with err_clr keeps the flag set.
    step(0, 1, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);

    // Reach 12 with overflow pending, then reset asynchronously between edges.
    pulse_inc(CAPACITY + 1);
    pulse_dec(8);
    @(posedge clk);
    #3;
    bus.inc = 1'b0; bus.dec = 1'b0; bus.clear = 1'b0; bus.err_clr = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    pulse_inc(1);

    // Randomized phases alternately biased toward filling and emptying the lot.
    pi = 0; pd = 0;
    for (int ph = 0; ph < 8; ph++) begin
      for (int n = 0; n < 150; n++) begin
        int pinc, pdec;
        pinc = (ph % 2 == 0) ? 55 : 15;
        pdec = (ph % 2 == 0) ? 15 : 55;
        pi = ($urandom_range(0, 99) < pinc) ? 1 : 0;
        pd = ($urandom_range(0, 99) < pdec) ? 1 : 0;
        step(pi, pd, ($urandom_range(0, 59) == 0) ? 1 : 0, ($urandom_range(0, 9) == 0) ? 1 : 0);
      end
    end
    step(0, 0, 0, 0);

    drain = 0;
    while (q.size() > 0 && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    #2;
    chk("scoreboard_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lot_occupancy_counter.md
Name: lot_occupancy_counter

Overview:
- Downstream consumer of the parking-lot sensor FSM's inc/dec outputs.
- Rising-edge-detects each car-entry (inc) and car-exit (dec) event and keeps a saturating occupancy count bounded by CAPACITY.
- Drives the display and gate logic: binary count, two-digit BCD count, free-space count, full/empty flags and sticky overflow/underflow error flags.

Parameters:
- CAPACITY, 20, number of parking spaces; legal range 1..99 and < 2**CW.
- CW, 7, width of the binary count and free_spaces outputs.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 resets all state.
- inc  input  1  car-entered level from the FSM; each 0->1 transition is one entry.
- dec  input  1  car-exited level from the FSM; each 0->1 transition is one exit.
- clear  input  1  synchronous clear of count to 0 (attendant override); does not touch the error flags.
- err_clr  input  1  synchronous clear of overflow/underflow.
- count  output  CW  current occupancy, 0..CAPACITY.
- bcd_tens  output  4  BCD tens digit of count.
- bcd_ones  output  4  BCD ones digit of count.
- free_spaces  output  CW  CAPACITY - count.
- full  output  1  count == CAPACITY.
- empty  output  1  count == 0.
- overflow  output  1  sticky: an entry occurred while full.
- underflow  output  1  sticky: an exit occurred while empty.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - count=0, bcd_tens=0, bcd_ones=0, free_spaces=CAPACITY, full=0, empty=1, overflow=0, underflow=0.
  - inc_q=0, dec_q=0.
- Edge detect:
  - inc_q and dec_q register the previous-cycle inc and dec.
  - inc_ev = inc & ~inc_q; dec_ev = dec & ~dec_q.
  - A level held high counts exactly once.
  - inc already high at the first edge after reset counts once.
- Latency: an event sampled at clock edge k appears on every output immediately after edge k (one registered stage). All outputs are registered or decoded from registered count; no combinational path from inputs to outputs.
- Update priority per edge:
  1. clear=1: count:=0; the edge detectors still update; events this cycle are discarded.
  2. inc_ev and dec_ev together: count unchanged, no error.
  3. inc_ev only: if count<CAPACITY then count+1, else hold and set overflow.
  4. dec_ev only: if count>0 then count-1, else hold and set underflow.
- Error flags: err_clr=1 clears both flags. A new error in the same cycle as err_clr wins: the flag stays set.
- BCD digits:
  - Maintained as a parallel BCD counter updated under the same conditions as count; not converted from the binary count.
  - On increment: ones wraps 9->0 and carries into tens.
  - On decrement: ones wraps 0->9 and borrows from tens.
  - Invariant: bcd_tens*10 + bcd_ones == count at all times.
- full/empty/free_spaces: decoded from registered count; full and empty are never both 1 (CAPACITY>=1).
- Count never leaves 0..CAPACITY under any input sequence.

Test Plan:
- Reset, then 3 separate inc pulses (each 2 cycles high) -> count=3, bcd=0/3, free_spaces=17, empty=0, full=0; each step visible one edge after the rising sample.
- inc held high for 50 cycles -> count increments exactly once (0->1).
- 20 entries, then one more inc -> count=20, full=1, bcd=2/0, overflow=1. Then err_clr -> overflow=0, count stays 20.
- From count=10 (bcd 1/0), one dec -> count=9, bcd=0/9. From empty, one dec -> count=0, underflow=1.
- inc and dec rising in the same cycle at count=5 -> count=5, no flags. clear=1 together with an inc edge at count=7 -> count=0.
- reset asserted mid-sequence (count=12, overflow=1) asynchronously between clock edges -> outputs take reset values immediately. After release, the next inc edge gives count=1.
